// File: rtl/bram_arb_pkg.sv
// Shared types, default sizes and the round-robin winner function for the
// BRAM port arbiter.
package bram_arb_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int DAT_W_DEF  = 18;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  // One-hot winner among the first n bits of valid, searching upward from ptr
  // and wrapping at n. Sized for the widest supported requester count (8).
  function automatic logic [7:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [7:0] grant;
    logic       found;
    logic [2:0] idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/bram_arb_mem.sv
// Single-port BRAM: synchronous write, registered read. Zero-initialised at
// configuration time unless ARB_CLEAR_EN provides a run-time clear instead.
module bram_arb_mem
  import bram_arb_pkg::*;
#(
  parameter int DAT_W  = DAT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DAT_W-1:0]  i_wdata,
  output logic [DAT_W-1:0]  o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef ARB_CLEAR_EN
  logic [DAT_W-1:0] r_mem [DEPTH];
`else
  logic [DAT_W-1:0] r_mem [DEPTH] = '{default: '0};
`endif

  logic [DAT_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (!RST)      r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bram_port_arb.sv
// Round-robin arbiter granting NREQ requesters one access per cycle to a BRAM.
// Define ARB_CLEAR_EN to build in the CLEAR state (zero-fill after reset and
// on clr_start).
//   state | meaning
//   RUN   | arbitrating requester accesses
//   CLEAR | writing zero to every address, one per cycle; no grants
module bram_port_arb
  import bram_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DAT_W  = DAT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ-1:0]                req_we,
  input  logic [NREQ-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NREQ-1:0][DAT_W-1:0]     req_wdata,
  output logic [NREQ-1:0]                req_ready,
  input  logic                           clr_start,
  output logic                           rsp_valid,
  output logic [$clog2(NREQ)-1:0]        rsp_id,
  output logic [DAT_W-1:0]               rsp_data,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NREQ);

  arb_state_t        w_state;
  logic              w_run;
  logic [IDX_W-1:0]  r_ptr;
  logic [7:0]        w_pick;
  logic              w_acc;
  logic              w_acc_we;
  logic              w_acc_re;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic              r_rsp_valid;
  logic [IDX_W-1:0]  r_rsp_id;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DAT_W-1:0]  w_mem_wdata;
  logic [DAT_W-1:0]  w_rdata;
  logic              w_unused;

  assign w_run     = RST && (w_state == RUN);
  assign w_pick    = rr_pick(8'(req_valid & {NREQ{w_run}}), 3'(r_ptr), NREQ);
  assign req_ready = w_pick[NREQ-1:0];
  assign w_acc     = |req_ready;

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) w_gnt_idx = IDX_W'(i);
    end
  end

  assign w_acc_we = w_acc &  req_we[w_gnt_idx];
  assign w_acc_re = w_acc & ~req_we[w_gnt_idx];

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      r_rsp_valid <= w_acc_re;
      if (w_acc)    r_ptr    <= (w_gnt_idx == IDX_W'(NREQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
      if (w_acc_re) r_rsp_id <= w_gnt_idx;
    end
  end

`ifdef ARB_CLEAR_EN
  arb_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_nxt;

  // Reset lands in CLEAR so the memory is zero-filled once reset releases.
  always_ff @(posedge clk) begin
    if (!RST) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      RUN: begin
        if (clr_start) begin
          w_state_nxt   = CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        if (&r_clr_cnt) begin
          w_state_nxt   = RUN;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        end
      end
    endcase
  end

  assign w_state    = r_state;
  assign w_clr_we   = RST && (r_state == CLEAR);
  assign w_clr_addr = r_clr_cnt;
  assign busy       = (r_state == CLEAR);
  assign w_unused   = &{1'b0, w_pick};
`else
  assign w_state    = RUN;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
  assign busy       = 1'b0;
  assign w_unused   = &{1'b0, w_pick, clr_start};
`endif

  assign w_mem_we    = w_clr_we | w_acc_we;
  assign w_mem_addr  = w_clr_we ? w_clr_addr : req_addr[w_gnt_idx];
  assign w_mem_wdata = w_clr_we ? '0 : req_wdata[w_gnt_idx];

  bram_arb_mem #(
    .DAT_W  (DAT_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .RST     (RST),
    .i_we    (w_mem_we),
    .i_re    (w_acc_re),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_rdata)
  );

  // Outputs read as zero for the whole time RST is low, so a response that
  // was in flight when reset hit never appears.
  assign rsp_valid = r_rsp_valid & RST;
  assign rsp_id    = RST ? r_rsp_id : '0;
  assign rsp_data  = RST ? w_rdata  : '0;

endmodule

// File: tb/tb_bram_port_arb.sv
// Scoreboard bench for bram_port_arb (NREQ=4, DAT_W=18, ADDR_W=4); follows
// the ARB_CLEAR_EN setting of the build.
module tb_bram_port_arb;

  localparam int NREQ   = 4;
  localparam int DAT_W  = 18;
  localparam int ADDR_W = 4;
`ifdef ARB_CLEAR_EN
  localparam int CLR_N = 16;
`else
  localparam int CLR_N = 0;
`endif

  logic                        clk = 1'b0;
  logic                        RST = 1'b0;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_we;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DAT_W-1:0]  req_wdata;
  logic [NREQ-1:0]             req_ready;
  logic                        clr_start;
  logic                        rsp_valid;
  logic [1:0]                  rsp_id;
  logic [DAT_W-1:0]            rsp_data;
  logic                        busy;

  bram_port_arb #(.NREQ(NREQ), .DAT_W(DAT_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .RST       (RST),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .clr_start (clr_start),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int data;
    int cyc;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int last_id = 0;
  int last_data = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response, checks hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!RST) begin
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_id", int'(rsp_id), 0);
      chk("rst_rsp_data", int'(rsp_data), 0);
      last_id   = 0;
      last_data = 0;
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("rsp_missing", 0, 1);
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rsp_cycle", cyc, e.cyc);
          chk("rsp_id", int'(rsp_id), e.id);
          chk("rsp_data", int'(rsp_data), e.data);
          last_id   = e.id;
          last_data = e.data;
        end
      end else begin
        chk("hold_id", int'(rsp_id), last_id);
        chk("hold_data", int'(rsp_data), last_data);
      end
    end
  end

  // Called at posedge+1; single requester, returns at posedge+1 after acceptance.
  task automatic do_access(input int who, input bit we, input int addr,
                           input int wd, input int exp);
    int n;
    req_valid        = '0;
    req_valid[who]   = 1'b1;
    req_we[who]      = we;
    req_addr[who]    = ADDR_W'(addr);
    req_wdata[who]   = DAT_W'(wd);
    n = 0;
    #2;
    while (!req_ready[who] && n < 40) begin
      @(posedge clk); #3;
      n++;
    end
    chk("grant", int'(req_ready), 1 << who);
    if (!we) q.push_back('{who, exp, cyc + 1});
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  // Counts busy cycles (from posedge+1); a second clr_start pulse mid-clear.
  task automatic run_clear(output int n);
    n = 0;
    while (busy && n < 100) begin
      chk("clr_ready", int'(req_ready), 0);
      clr_start = (n == 5);
      @(posedge clk); #1;
      n++;
    end
    clr_start = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    clr_start = 1'b0;
    for (int i = 0; i < NREQ; i++) req_addr[i] = ADDR_W'(i);

    repeat (3) begin
      @(posedge clk); #1;
      req_valid = 4'hF;
      #2;
      chk("rst_ready", int'(req_ready), 0);
    end
    @(posedge clk); #1;
    RST = 1'b1;
`ifdef ARB_CLEAR_EN
    req_valid = 4'hF;
`else
    req_valid = '0;
`endif
    chk("busy_after_rst", int'(busy), CLR_N > 0 ? 1 : 0);
    run_clear(n);
    req_valid = '0;
    chk("clr_cycles_rst", n, CLR_N);

    // Fairness from p=0: all four hold reads of addresses 0..3 (all zero).
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #2;
      g = k % 4;
      chk("fair_grant", int'(req_ready), 1 << g);
      q.push_back('{g, 0, cyc + 1});
      @(posedge clk); #1;
    end
    req_valid = '0;

    do_access(2, 1'b1, 7, 'h155, 0);
    do_access(1, 1'b0, 7, 0, 'h155);
    do_access(3, 1'b1, 5, 'h3A, 0);
    do_access(0, 1'b0, 5, 0, 'h3A);
    do_access(0, 1'b1, 15, 'h3FFFF, 0);
    do_access(3, 1'b0, 15, 0, 'h3FFFF);
    do_access(1, 1'b1, 0, 'h1234, 0);
    do_access(2, 1'b0, 0, 0, 'h1234);

`ifdef ARB_CLEAR_EN
    for (int a = 0; a < 16; a++) do_access(a % 4, 1'b1, a, 'h2AAAA, 0);
`endif

    // clr_start together with a read on requester 1.
    req_valid    = 4'b0010;
    req_we[1]    = 1'b0;
    req_addr[1]  = ADDR_W'(3);
    clr_start    = 1'b1;
    #2;
    chk("clr_cycle_grant", int'(req_ready), 4'b0010);
`ifdef ARB_CLEAR_EN
    q.push_back('{1, 'h2AAAA, cyc + 1});
`else
    q.push_back('{1, 0, cyc + 1});
`endif
    @(posedge clk); #1;
    clr_start = 1'b0;
    req_we    = '0;
    req_valid = 4'hF;
    chk("busy_after_pulse", int'(busy), CLR_N > 0 ? 1 : 0);
    run_clear(n);
    req_valid = '0;
    chk("clr_cycles", n, CLR_N);

`ifdef ARB_CLEAR_EN
    for (int a = 0; a < 16; a++) do_access(a % 4, 1'b0, a, 0, 0);
`else
    do_access(0, 1'b0, 7, 0, 'h155);
    do_access(3, 1'b0, 15, 0, 'h3FFFF);
`endif

    // Reset one cycle after an accepted read; pointer would otherwise be 3.
    req_valid   = 4'b0100;
    req_we[2]   = 1'b0;
    req_addr[2] = ADDR_W'(7);
    #2;
    chk("pre_rst_grant", int'(req_ready), 4'b0100);
    @(posedge clk); #1;
    RST       = 1'b0;
    req_valid = '0;
    repeat (2) begin @(posedge clk); #1; end
    RST = 1'b1;
    run_clear(n);
    chk("clr_cycles_rst2", n, CLR_N);
    req_valid   = 4'b1010;
    req_addr[1] = ADDR_W'(7);
    req_addr[3] = ADDR_W'(7);
    #2;
    chk("post_rst_grant", int'(req_ready), 4'b0010);
`ifdef ARB_CLEAR_EN
    q.push_back('{1, 0, cyc + 1});
`else
    q.push_back('{1, 'h155, cyc + 1});
`endif
    @(posedge clk); #1;
    req_valid = '0;

    repeat (3) begin @(posedge clk); #1; end
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
